unum4_multiply: RTL and testbench

- Serial shift-add multiplier for unum4 (mantissa, exponent) operands. It is the multiplicative counterpart of the serial divide unit and shares that unit's operand format and start/done interface.
- Sits in the unum4 arithmetic datapath beside the add/sub and divide units and is started by the same operation controller.
- Produces a normalized, truncated two's-complement mantissa, a combined exponent, and overflow/underflow flags.

---
 rtl/unum4_multiply.sv | 180 ++++++++++++++++++
 tb/tb_unum4_multiply.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unum4_multiply.sv
// unum4_multiply: serial shift-add multiplier for unum4 (mantissa, exponent) operands.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             request pulse, sampled only while idle
//   busy              high in every state except idle
//   done              one-cycle result-valid pulse (high during the output state)
//   m_a, m_b          signed Q1.(W-1) operand mantissas
//   e_a, e_b          signed operand exponents
//   m_o               normalized, truncated product mantissa with EXTRA zero LSBs appended
//   e_o               product exponent
//   over, under       exponent overflow / underflow for the current result
//
// Flow: idle (capture) -> W multiply cycles (LSB first) -> normalize -> output.
// Results are registered on entry to the output state so they are valid while done is high.
module unum4_multiply #(
  parameter int unsigned MAN_MAX_W = 29,
  parameter int unsigned EXP_MAX_W = 16,
  parameter int unsigned EXTRA     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [MAN_MAX_W-1:0]          m_a,
  input  logic [MAN_MAX_W-1:0]          m_b,
  input  logic [EXP_MAX_W-1:0]          e_a,
  input  logic [EXP_MAX_W-1:0]          e_b,
  output logic [MAN_MAX_W+EXTRA-1:0]    m_o,
  output logic [EXP_MAX_W-1:0]          e_o,
  output logic                          over,
  output logic                          under
);

  localparam int unsigned W   = MAN_MAX_W;
  localparam int unsigned EW  = EXP_MAX_W;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned XW  = EW + 2;
  localparam int unsigned CW  = $clog2(W + 1);
  localparam int unsigned LZW = $clog2(PW + 1);

  localparam int EMaxI = (2 ** (EW - 1)) - 1;
  localparam logic signed [XW-1:0] EMax = XW'(EMaxI);
  localparam logic signed [XW-1:0] EMin = XW'(-EMaxI - 1);
  localparam logic [W-1:0] One = W'(1);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StOut} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          acc_q, acc_d;
  logic [PW-1:0]          mcand_q, mcand_d;   // |A| shifted left one place per cycle
  logic [W-1:0]           mplier_q, mplier_d; // |B| shifted right one place per cycle
  logic                   sign_q, sign_d;
  logic                   zero_q, zero_d;
  logic signed [XW-1:0]   esum_q, esum_d;

  logic [W+EXTRA-1:0]     m_o_q, m_o_d;
  logic [EW-1:0]          e_o_q, e_o_d;
  logic                   over_q, over_d;
  logic                   under_q, under_d;

  // Normalization datapath, evaluated from the finished accumulator
  logic [LZW-1:0]         lz;
  logic [W-2:0]           mag;
  logic signed [XW-1:0]   e_res;
  logic [W-1:0]           man;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + One) : v;
  endfunction

  always_comb begin
    lz = LZW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (acc_q[i]) lz = LZW'(PW - 1 - i);
    end
    mag   = (W - 1)'((acc_q << lz) >> (W + 1));
    e_res = esum_q + XW'(2) - $signed(XW'(lz));
    man   = sign_q ? (~{1'b0, mag} + One) : {1'b0, mag};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    esum_d   = esum_q;
    m_o_d    = m_o_q;
    e_o_d    = e_o_q;
    over_d   = over_q;
    under_d  = under_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = PW'(abs_mag(m_a));
          mplier_d = abs_mag(m_b);
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = m_a[W-1] ^ m_b[W-1];
          zero_d   = (m_a == '0) || (m_b == '0);
          esum_d   = $signed({{2{e_a[EW-1]}}, e_a}) + $signed({{2{e_b[EW-1]}}, e_b});
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = StNorm;
      end
      StNorm: begin
        m_o_d   = '0;
        e_o_d   = '0;
        over_d  = 1'b0;
        under_d = 1'b0;
        if (zero_q) begin
          // all-zero result already set above
        end else if (e_res > EMax) begin
          over_d = 1'b1;
        end else if (e_res < EMin) begin
          under_d = 1'b1;
        end else begin
          m_o_d[W+EXTRA-1:EXTRA] = man;
          e_o_d                  = e_res[EW-1:0];
        end
        state_d = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      esum_q   <= '0;
      m_o_q    <= '0;
      e_o_q    <= '0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      esum_q   <= esum_d;
      m_o_q    <= m_o_d;
      e_o_q    <= e_o_d;
      over_q   <= over_d;
      under_q  <= under_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StOut);
  assign m_o   = m_o_q;
  assign e_o   = e_o_q;
  assign over  = over_q;
  assign under = under_q;

endmodule

// File: tb/tb_unum4_multiply.sv
// Testbench for unum4_multiply: two instances (EXTRA=0 and EXTRA=3) share stimulus;
// expected results come from a value-level reference model through a scoreboard queue.
module tb_unum4_multiply;

  localparam int W  = 29;
  localparam int EW = 16;

  typedef struct {
    logic [W-1:0]  m;
    logic [EW-1:0] e;
    logic          ov;
    logic          un;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  m_a, m_b;
  logic [EW-1:0] e_a, e_b;

  logic          busy0, done0, over0, under0;
  logic [W-1:0]  m_o0;
  logic [EW-1:0] e_o0;
  logic          busy3, done3, over3, under3;
  logic [W+2:0]  m_o3;
  logic [EW-1:0] e_o3;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  unum4_multiply #(.MAN_MAX_W(W), .EXP_MAX_W(EW), .EXTRA(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
    .m_a(m_a), .m_b(m_b), .e_a(e_a), .e_b(e_b),
    .m_o(m_o0), .e_o(e_o0), .over(over0), .under(under0)
  );

  unum4_multiply #(.MAN_MAX_W(W), .EXP_MAX_W(EW), .EXTRA(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3),
    .m_a(m_a), .m_b(m_b), .e_a(e_a), .e_b(e_b),
    .m_o(m_o3), .e_o(e_o3), .over(over3), .under(under3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value-level model: product p/2^(2W-2) renormalized so the magnitude has its top bit at
  // position W-2, i.e. value = mag/2^(W-1) * 2^e.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [EW-1:0] ea, input logic [EW-1:0] eb);
    exp_t   r;
    longint sa, sb_v, p, ap, es, mg, e;
    int     h;
    r.m = '0; r.e = '0; r.ov = 1'b0; r.un = 1'b0;
    sa   = longint'($signed(ma));
    sb_v = longint'($signed(mb));
    p    = sa * sb_v;
    ap   = (p < 0) ? -p : p;
    es   = longint'($signed(ea)) + longint'($signed(eb));
    if (ap == 0) return r;
    h = 0;
    for (int i = 0; i < 63; i++) if (ap[i]) h = i;
    mg = (h >= W - 2) ? (ap >> (h - (W - 2))) : (ap << ((W - 2) - h));
    e  = es + h - (2 * W - 3);
    if (e > 32767) r.ov = 1'b1;
    else if (e < -32768) r.un = 1'b1;
    else begin
      r.m = (p < 0) ? W'(-mg) : W'(mg);
      r.e = EW'(e);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic [EW-1:0] ea, input logic [EW-1:0] eb, input bit hold);
    exp_t x;
    int   lat;
    bit   seen;
    check({tag, "_idle"}, 64'(busy0), 64'(0));
    m_a = ma; m_b = mb; e_a = ea; e_b = eb;
    start = 1'b1;
    sb.push_back(model(ma, mb, ea, eb));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= W + 10 && !seen; k++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1;
        lat  = k;
      end else begin
        m_a = W'($urandom); m_b = W'($urandom);
        e_a = EW'($urandom); e_b = EW'($urandom);
      end
    end
    if (hold) start = 1'b0;
    check({tag, "_done"}, 64'(seen), 64'(1));
    check({tag, "_lat"}, 64'(lat), 64'(W + 2));
    x = sb.pop_front();
    if (seen) begin
      check({tag, "_m"}, 64'(m_o0), 64'(x.m));
      check({tag, "_e"}, 64'(e_o0), 64'(x.e));
      check({tag, "_ov"}, 64'(over0), 64'(x.ov));
      check({tag, "_un"}, 64'(under0), 64'(x.un));
      check({tag, "_done3"}, 64'(done3), 64'(1));
      check({tag, "_m3"}, 64'(m_o3), 64'({x.m, 3'b000}));
      check({tag, "_e3"}, 64'(e_o3), 64'(x.e));
    end
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;
    logic [EW-1:0] rea, reb;

    rst_n = 1'b0; start = 1'b0;
    m_a = '0; m_b = '0; e_a = '0; e_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'(0));
    check("rst_done", 64'(done0), 64'(0));
    check("rst_m", 64'(m_o0), 64'(0));
    check("rst_e", 64'(e_o0), 64'(0));
    check("rst_flags", 64'({over0, under0}), 64'(0));
    check("rst_m3", 64'(m_o3), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 0.5 x 0.5 = 0.25 = 0.5 * 2^-1
    run_op("half", 29'h0800_0000, 29'h0800_0000, 16'h0000, 16'h0000, 0);
    check("half_m_c", 64'(m_o0), 64'(29'h0800_0000));
    check("half_e_c", 64'(e_o0), 64'(16'hFFFF));
    @(negedge clk);
    // -1 x -1 with exponents 3,4 -> 0.5 * 2^8
    run_op("neg1", 29'h1000_0000, 29'h1000_0000, 16'd3, 16'd4, 0);
    check("neg1_m_c", 64'(m_o0), 64'(29'h0800_0000));
    check("neg1_e_c", 64'(e_o0), 64'(16'd8));
    @(negedge clk);
    // -1 x 0.5 -> -0.5
    run_op("mix", 29'h1000_0000, 29'h0800_0000, 16'd0, 16'd0, 0);
    check("mix_m_c", 64'(m_o0), 64'(29'h1800_0000));
    check("mix_e_c", 64'(e_o0), 64'(16'd0));
    @(negedge clk);

    // Zero operand with start held through the whole operation
    run_op("zero", 29'h0, 29'h0ABC_DEF0, 16'h7FFF, 16'h0000, 1);
    check("zero_m_c", 64'(m_o0), 64'(0));
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0 || busy0) cnt++;
    end
    check("zero_no_second", 64'(cnt), 64'(0));

    // Overflow: e_res = 0x8000 + 2 - 1
    run_op("ovf", 29'h1000_0000, 29'h1000_0000, 16'h4000, 16'h4000, 0);
    check("ovf_c", 64'({over0, under0, m_o0, e_o0}), 64'({2'b10, 29'h0, 16'h0}));
    @(negedge clk);
    // Boundary: e_res = 0x8000 + 2 - 3 = 0x7FFF is still representable
    run_op("emax", 29'h0800_0000, 29'h0800_0000, 16'h4000, 16'h4000, 0);
    check("emax_c", 64'({over0, under0, e_o0}), 64'({2'b00, 16'h7FFF}));
    @(negedge clk);
    run_op("unf", 29'h0800_0000, 29'h0800_0000, 16'hC000, 16'hC000, 0);
    check("unf_c", 64'({over0, under0, m_o0, e_o0}), 64'({2'b01, 29'h0, 16'h0}));
    @(negedge clk);
    run_op("clr", 29'h0C00_0000, 29'h0A00_0000, 16'd5, 16'hFFFE, 0);
    check("clr_flags", 64'({over0, under0}), 64'(0));

    // start asserted only during the done cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("out_start_ignored", 64'(busy0), 64'(0));

    // Asynchronous reset during multiply cycle 10
    m_a = 29'h0800_0000; m_b = 29'h0C00_0000; e_a = 16'd1; e_b = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy0), 64'(0));
    check("abort_done", 64'(done0), 64'(0));
    check("abort_m", 64'(m_o0), 64'(0));
    check("abort_e", 64'(e_o0), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'(0));
    run_op("post_rst", 29'h0555_5555, 29'h1234_5678, 16'd10, 16'hFFF0, 0);

    // Random regression, issued back to back (next start in the idle cycle after done)
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: ra = 29'h1000_0000;
        1: rb = W'($urandom_range(0, 3));
        2: ra = W'(1);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        rea = EW'($urandom);
        reb = EW'($urandom);
      end else begin
        rea = EW'($urandom_range(0, 400)) - EW'(200);
        reb = EW'($urandom_range(0, 400)) - EW'(200);
      end
      run_op("rand", ra, rb, rea, reb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
